// File: rtl/lsnn_pkg.sv
// Shared definitions for the spike-rate decoder: FSM states, default
// geometry and the saturating-max helper used by the counters.
package lsnn_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned DEF_WIN_LOG2 = 4;
  localparam int unsigned DEF_CW       = 8;

  function automatic int unsigned sat_max(input int unsigned width);
    if (width >= 32) return 32'hFFFF_FFFF;
    return (32'd1 << width) - 32'd1;
  endfunction

endpackage

// File: rtl/lsnn_sat_counter.sv
// Saturating up-counter with synchronous clear; reset value is either zero
// or full scale. next_value exposes the pre-clear increment result.
module lsnn_sat_counter
  import lsnn_pkg::*;
#(
  parameter int unsigned W       = DEF_CW,
  parameter bit          RST_SAT = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] value,
  output logic [W-1:0] next_value
);

  localparam logic [W-1:0] MAX = W'(sat_max(W));

  assign next_value = (en && (value != MAX)) ? value + W'(1) : value;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      value <= RST_SAT ? MAX : '0;
    else if (clr) value <= '0;
    else          value <= next_value;
  end

endmodule

// File: rtl/lsnn_spike_rate_decoder.sv
// Windowed spike-rate / peak-threshold decoder with a one-deep result slot,
// plus an inter-spike-interval monitor that runs independently of en.
module lsnn_spike_rate_decoder
  import lsnn_pkg::*;
#(
  parameter int unsigned WIN_LOG2 = DEF_WIN_LOG2,
  parameter int unsigned CW       = DEF_CW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          spike_in,
  input  logic [7:0]    thresh_in,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [CW-1:0] rate_out,
  output logic [7:0]    peak_thr,
  output logic [CW-1:0] isi_out,
  output logic          isi_valid,
  output logic          overrun
);

  localparam logic [CW-1:0] ISI_MAX = CW'(sat_max(CW));

  state_t              state, state_next;
  logic                counting, terminal, slot_free;
  logic [WIN_LOG2-1:0] win;
  logic [CW-1:0]       count, count_next, isi_count, isi_next;
  logic [7:0]          peak, peak_next;
  logic                no_prior;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    counting   = 1'b0;
    case (state)
      IDLE: if (en) state_next = RUN;
      RUN:  if (en) counting = 1'b1;
            else    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign terminal  = counting && (win == '1);
  assign slot_free = !out_valid || out_ready;
  assign peak_next = (thresh_in > peak) ? thresh_in : peak;

  // Clearing on terminal lets the next window start from 0 while the
  // terminal cycle's own contribution is captured via count_next.
  lsnn_sat_counter #(.W(CW), .RST_SAT(1'b0)) u_rate (
    .clk        (clk),
    .rst        (rst_n),
    .en         (counting && spike_in),
    .clr        (!counting || terminal),
    .value      (count),
    .next_value (count_next)
  );

  lsnn_sat_counter #(.W(CW), .RST_SAT(1'b1)) u_isi (
    .clk        (clk),
    .rst        (rst_n),
    .en         (1'b1),
    .clr        (spike_in),
    .value      (isi_count),
    .next_value (isi_next)
  );

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      win  <= '0;
      peak <= '0;
    end else if (!counting || terminal) begin
      win  <= '0;
      peak <= '0;
    end else begin
      win  <= win + WIN_LOG2'(1);
      peak <= peak_next;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      out_valid <= 1'b0;
      rate_out  <= '0;
      peak_thr  <= '0;
      overrun   <= 1'b0;
    end else if (terminal && slot_free) begin
      out_valid <= 1'b1;
      rate_out  <= count_next;
      peak_thr  <= peak_next;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (terminal)               overrun   <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      isi_out   <= '0;
      isi_valid <= 1'b0;
      no_prior  <= 1'b1;
    end else begin
      isi_valid <= spike_in;
      if (spike_in) begin
        isi_out  <= no_prior ? ISI_MAX : isi_next;
        no_prior <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lsnn_spike_rate_decoder.sv
// Directed plus random stimulus for the spike-rate decoder, checked each
// cycle against an integer-arithmetic window/ISI model.
module tb_lsnn_spike_rate_decoder;

  localparam int WIN_LEN = 16;
  localparam int SAT     = 255;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0, spike = 1'b0, out_ready = 1'b0;
  logic [7:0] thresh = '0;

  logic       o_valid, o_isi_valid, o_overrun;
  logic [7:0] o_rate, o_peak, o_isi;
  logic       o9_valid, o9_isi_valid, o9_overrun;
  logic [7:0] o9_rate, o9_peak, o9_isi;

  int n_assert = 0;
  int n_fail   = 0;

  int m_running, m_pos, m_cnt, m_pk, m_valid, m_rate, m_peak, m_ovr;
  int m_isi_cnt, m_seen, m_isi_out, m_isi_valid;

  always #5 clk = ~clk;

  lsnn_spike_rate_decoder dut (
    .clk(clk), .rst_n(rst), .en(en), .spike_in(spike), .thresh_in(thresh),
    .out_ready(out_ready), .out_valid(o_valid), .rate_out(o_rate),
    .peak_thr(o_peak), .isi_out(o_isi), .isi_valid(o_isi_valid),
    .overrun(o_overrun)
  );

  lsnn_spike_rate_decoder #(.WIN_LOG2(9), .CW(8)) dut9 (
    .clk(clk), .rst_n(rst), .en(en), .spike_in(spike), .thresh_in(thresh),
    .out_ready(out_ready), .out_valid(o9_valid), .rate_out(o9_rate),
    .peak_thr(o9_peak), .isi_out(o9_isi), .isi_valid(o9_isi_valid),
    .overrun(o9_overrun)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_running = 0; m_pos = 0; m_cnt = 0; m_pk = 0;
    m_valid = 0; m_rate = 0; m_peak = 0; m_ovr = 0;
    m_isi_cnt = SAT; m_seen = 0; m_isi_out = 0; m_isi_valid = 0;
  endtask

  task automatic model_step();
    int c, p, old_valid;
    if (spike) begin
      m_isi_out   = m_seen ? ((m_isi_cnt + 1 > SAT) ? SAT : m_isi_cnt + 1) : SAT;
      m_isi_valid = 1;
      m_isi_cnt   = 0;
      m_seen      = 1;
    end else begin
      m_isi_valid = 0;
      if (m_isi_cnt < SAT) m_isi_cnt++;
    end
    old_valid = m_valid;
    if (m_valid && out_ready) m_valid = 0;
    if (m_running && en) begin
      c = m_cnt + int'(spike);
      if (c > SAT) c = SAT;
      p = (int'(thresh) > m_pk) ? int'(thresh) : m_pk;
      if (m_pos == WIN_LEN - 1) begin
        if (!old_valid || out_ready) begin
          m_valid = 1; m_rate = c; m_peak = p;
        end else m_ovr = 1;
        m_cnt = 0; m_pk = 0; m_pos = 0;
      end else begin
        m_cnt = c; m_pk = p; m_pos++;
      end
    end else begin
      m_cnt = 0; m_pk = 0; m_pos = 0;
      m_running = int'(en);
    end
  endtask

  task automatic compare_all();
    check("out_valid", 32'(o_valid), m_valid);
    check("rate_out",  32'(o_rate),  m_rate);
    check("peak_thr",  32'(o_peak),  m_peak);
    check("isi_out",   32'(o_isi),   m_isi_out);
    check("isi_valid", 32'(o_isi_valid), m_isi_valid);
    check("overrun",   32'(o_overrun), m_ovr);
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_valid",     32'(o_valid), 0);
    check("rst_rate",      32'(o_rate), 0);
    check("rst_peak",      32'(o_peak), 0);
    check("rst_isi",       32'(o_isi), 0);
    check("rst_isi_valid", 32'(o_isi_valid), 0);
    check("rst_overrun",   32'(o_overrun), 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    model_reset();

    // Continuous spikes, always ready: one-cycle result pulse on edge 17.
    en = 1; spike = 1; out_ready = 1; thresh = 8'd3;
    do_reset();
    for (int e = 1; e <= 18; e++) begin
      step();
      if (e == 16) check("cont_valid_e16", 32'(o_valid), 0);
      if (e == 17) begin
        check("cont_valid_e17", 32'(o_valid), 1);
        check("cont_rate_e17",  32'(o_rate), 16);
      end
      if (e == 18) check("cont_valid_e18", 32'(o_valid), 0);
    end

    // Alternate spikes, never ready: held result and overrun on edge 33.
    en = 1; spike = 0; out_ready = 0;
    do_reset();
    for (int e = 1; e <= 40; e++) begin
      spike = logic'(e % 2);
      step();
      if (e == 17) check("alt_rate_e17", 32'(o_rate), 8);
      if (e == 32) check("alt_ovr_e32", 32'(o_overrun), 0);
      if (e == 33) check("alt_ovr_e33", 32'(o_overrun), 1);
      if (e == 40) begin
        check("alt_rate_e40",  32'(o_rate), 8);
        check("alt_valid_e40", 32'(o_valid), 1);
      end
    end

    // ISI: spikes on edges 3 and 10.
    en = 0; out_ready = 1;
    do_reset();
    for (int e = 1; e <= 12; e++) begin
      spike = (e == 3 || e == 10);
      step();
      if (e == 3) begin
        check("isi_first_valid", 32'(o_isi_valid), 1);
        check("isi_first_val",   32'(o_isi), 255);
      end
      if (e == 4) check("isi_pulse_end", 32'(o_isi_valid), 0);
      if (e == 10) begin
        check("isi_second_valid", 32'(o_isi_valid), 1);
        check("isi_second_val",   32'(o_isi), 7);
      end
    end

    // Threshold ramp 8..40 inside one window, then back to 8.
    en = 1; spike = 0; out_ready = 1;
    do_reset();
    for (int e = 1; e <= 17; e++) begin
      thresh = (e >= 2 && e <= 10) ? 8'(8 + 4 * (e - 2)) : 8'd8;
      step();
    end
    check("ramp_peak", 32'(o_peak), 40);
    check("ramp_valid", 32'(o_valid), 1);

    // Reset at window position 9 after five spikes.
    en = 1; out_ready = 1; thresh = 8'd20;
    do_reset();
    for (int e = 1; e <= 10; e++) begin
      spike = (e >= 2 && e <= 6);
      step();
    end
    spike = 0;
    #2;
    do_reset();
    for (int e = 1; e <= 17; e++) begin
      spike = (e == 4 || e == 7 || e == 9);
      step();
    end
    check("midrst_rate",  32'(o_rate), 3);
    check("midrst_valid", 32'(o_valid), 1);

    // Acceptance on the same cycle as the next terminal count.
    en = 1; out_ready = 0; thresh = 8'd0;
    do_reset();
    for (int e = 1; e <= 34; e++) begin
      spike = (e <= 17) ? 1'b1 : logic'(e % 2 == 0);
      out_ready = (e == 33);
      step();
      if (e == 17) check("acc_first_rate", 32'(o_rate), 16);
      if (e == 33) begin
        check("acc_valid_e33", 32'(o_valid), 1);
        check("acc_rate_e33",  32'(o_rate), 8);
        check("acc_ovr_e33",   32'(o_overrun), 0);
      end
    end
    out_ready = 0;

    // Long window on the second instance saturates the count.
    en = 1; spike = 1; out_ready = 1; thresh = 8'd0;
    do_reset();
    for (int e = 1; e <= 513; e++) begin
      step();
      if (e == 512) check("sat_valid_e512", 32'(o9_valid), 0);
    end
    check("sat_valid", 32'(o9_valid), 1);
    check("sat_rate",  32'(o9_rate), 255);

    // Random traffic against the model.
    do_reset();
    for (int e = 0; e < 400; e++) begin
      en        = ($urandom_range(0, 15) != 0);
      spike     = logic'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) == 0);
      thresh    = 8'($urandom_range(0, 255));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
